// File: rtl/div8x4_seq_if.sv
// Request/result bundle for the 8-by-4 sequential divider.
interface div8x4_seq_if;
  logic       start;
  logic [7:0] dividend;
  logic [3:0] divisor;
  logic [7:0] quotient;
  logic [3:0] remainder;
  logic       busy;
  logic       done;
  logic       div_by_zero;

  // Requester side: drives operands, observes results.
  modport master (
    output start,
    output dividend,
    output divisor,
    input  quotient,
    input  remainder,
    input  busy,
    input  done,
    input  div_by_zero
  );

  // Divider side: samples operands, drives results.
  modport slave (
    input  start,
    input  dividend,
    input  divisor,
    output quotient,
    output remainder,
    output busy,
    output done,
    output div_by_zero
  );
endinterface

// File: rtl/div8x4_seq.sv
// Restoring unsigned divider, 8-bit dividend by 4-bit divisor, one quotient bit per cycle.
// A divide-by-zero request skips the iteration phase and completes on the next cycle.
module div8x4_seq (
  input logic         clk,
  input logic         rst,
  div8x4_seq_if.slave bus
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] dvd_q, dvd_d;       // captured dividend, stable for the whole run
  logic [3:0] dvs_q, dvs_d;       // captured divisor
  logic [4:0] rem_q, rem_d;       // partial remainder
  logic [2:0] cnt_q, cnt_d;       // iteration index, 0..7
  logic [6:0] acc_q, acc_d;       // quotient bits gathered so far
  logic [7:0] quotient_q, quotient_d;
  logic [3:0] remainder_q, remainder_d;
  logic       dbz_q, dbz_d;

  // One iteration of the restoring step, driven purely from the current registers.
  logic       next_bit;
  logic [4:0] trial;
  logic [4:0] dvs_ext;
  logic       fits;
  logic [4:0] rem_step;

  always_comb begin
    // ~cnt_q == 7 - cnt_q, so the dividend is consumed MSB first.
    next_bit = dvd_q[~cnt_q];
    trial    = (rem_q << 1) | {4'b0000, next_bit};
    dvs_ext  = {1'b0, dvs_q};
    fits     = (trial >= dvs_ext);
    rem_step = fits ? (trial - dvs_ext) : trial;
  end

  // Next-state, operand capture and result loading.
  always_comb begin
    state_d     = state_q;
    dvd_d       = dvd_q;
    dvs_d       = dvs_q;
    rem_d       = rem_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;

    unique case (state_q)
      StIdle, StDone: begin
        if (bus.start) begin
          dvd_d = bus.dividend;
          dvs_d = bus.divisor;
          rem_d = 5'd0;
          cnt_d = 3'd0;
          acc_d = 7'd0;
          if (bus.divisor == 4'd0) begin
            state_d     = StDone;
            quotient_d  = 8'hFF;
            remainder_d = bus.dividend[3:0];
            dbz_d       = 1'b1;
          end else begin
            state_d = StRun;
          end
        end else begin
          state_d = StIdle;
        end
      end

      StRun: begin
        rem_d = rem_step;
        acc_d = {acc_q[5:0], fits};
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          // Last iteration: publish the result in one step so no partial value is visible.
          state_d     = StDone;
          quotient_d  = {acc_q, fits};
          remainder_d = rem_step[3:0];
          dbz_d       = 1'b0;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      dvd_q       <= 8'd0;
      dvs_q       <= 4'd0;
      rem_q       <= 5'd0;
      cnt_q       <= 3'd0;
      acc_q       <= 7'd0;
      quotient_q  <= 8'd0;
      remainder_q <= 4'd0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      dvd_q       <= dvd_d;
      dvs_q       <= dvs_d;
      rem_q       <= rem_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
    end
  end

  // Status flags decode directly from the state register.
  always_comb begin
    bus.busy        = (state_q == StRun);
    bus.done        = (state_q == StDone);
    bus.quotient    = quotient_q;
    bus.remainder   = remainder_q;
    bus.div_by_zero = dbz_q;
  end

endmodule
